// File: rtl/cc_rank_sched_pkg.sv
// Shared types, widths and encodings for the seven-student rank-and-grade block.
package cc_pkg;
  localparam int N_STU   = 7;
  localparam int SCORE_W = 4;
  localparam int EXT_W   = 5;
  localparam int LIN_W   = 7;
  localparam int ID_W    = 3;
  localparam int CNT_W   = 3;
  localparam int SUM_W   = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CALC, ST_OUT} state_e;

  // Transform select: identity, or scale by 2/3/4 (divide for negative scores).
  localparam logic [1:0] TR_X1 = 2'd0;
  localparam logic [1:0] TR_X2 = 2'd1;
  localparam logic [1:0] TR_X3 = 2'd2;
  localparam logic [1:0] TR_X4 = 2'd3;

  typedef struct packed {
    logic       sgn;
    logic       desc;
    logic       fail;
    logic [1:0] a;
    logic [2:0] b;
  } cfg_t;

  function automatic logic [EXT_W-1:0] ext_score(input logic [SCORE_W-1:0] s, input logic sgn);
    return {sgn & s[SCORE_W-1], s};
  endfunction
endpackage

// File: rtl/cc_rank_sched_if.sv
// Serial score-in / ranked-ID-out bus of the rank scheduler.
interface cc_rank_sched_if;
  import cc_pkg::*;
  logic               in_valid;
  logic [SCORE_W-1:0] in_score;
  logic [2:0]         in_opt;
  logic [1:0]         in_a;
  logic [2:0]         in_b;
  logic               busy;
  logic               out_valid;
  logic [ID_W-1:0]    out_id;
  logic [CNT_W-1:0]   out_cnt;

  modport master (output in_valid, in_score, in_opt, in_a, in_b,
                  input  busy, out_valid, out_id, out_cnt);
  modport slave  (input  in_valid, in_score, in_opt, in_a, in_b,
                  output busy, out_valid, out_id, out_cnt);
endinterface

// File: rtl/cc_rank_core.sv
// Combinational ranking core: stable sort, average threshold, transform and count.
module cc_rank_core
  import cc_pkg::*;
(
  input  logic [N_STU-1:0][EXT_W-1:0] ext_i,
  input  cfg_t                        cfg_i,
  output logic [N_STU-1:0][ID_W-1:0]  id_o,
  output logic [CNT_W-1:0]            cnt_o
);
  logic [N_STU-1:0][ID_W-1:0] pos;
  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    avg8;
  logic signed [EXT_W-1:0]    avg;
  logic signed [LIN_W-1:0]    thr;
  logic [N_STU-1:0]           below;
  logic [CNT_W-1:0]           n_below;

  // Rank by counting predecessors; ties resolve to the lower ID, which keeps the sort stable.
  always_comb begin
    for (int i = 0; i < N_STU; i++) begin
      pos[i] = '0;
      for (int j = 0; j < N_STU; j++) begin
        if (j != i) begin
          if ($signed(ext_i[j]) == $signed(ext_i[i])) begin
            if (j < i) pos[i] = pos[i] + ID_W'(1);
          end else if (($signed(ext_i[j]) > $signed(ext_i[i])) == cfg_i.desc) begin
            pos[i] = pos[i] + ID_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    id_o = '0;
    for (int p = 0; p < N_STU; p++)
      for (int i = 0; i < N_STU; i++)
        if (pos[i] == ID_W'(p)) id_o[p] = ID_W'(i);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_STU; i++)
      sum = sum + $signed({{(SUM_W-EXT_W){ext_i[i][EXT_W-1]}}, ext_i[i]});
  end

  // Signed division truncates toward zero; |sum|/7 always fits in EXT_W bits.
  assign avg8 = sum / 8'sd7;
  assign avg  = avg8[EXT_W-1:0];
  assign thr  = $signed({{(LIN_W-EXT_W){avg[EXT_W-1]}}, avg})
              - $signed({{(LIN_W-2){1'b0}}, cfg_i.a})
              - $signed({{(LIN_W-3){1'b0}}, cfg_i.b});

  for (genvar g = 0; g < N_STU; g++) begin : g_lane
    logic signed [LIN_W-1:0] x;
    logic signed [LIN_W-1:0] t;
    always_comb begin
      x = $signed({{(LIN_W-EXT_W){ext_i[g][EXT_W-1]}}, ext_i[g]});
      case (cfg_i.a)
        TR_X2:   t = x[LIN_W-1] ? x / 7'sd2 : x * 7'sd2;
        TR_X3:   t = x[LIN_W-1] ? x / 7'sd3 : x * 7'sd3;
        TR_X4:   t = x[LIN_W-1] ? x / 7'sd4 : x * 7'sd4;
        default: t = x;
      endcase
    end
    assign below[g] = t < thr;
  end

  always_comb begin
    n_below = '0;
    for (int i = 0; i < N_STU; i++)
      n_below = n_below + CNT_W'(below[i]);
  end

  assign cnt_o = cfg_i.fail ? n_below : CNT_W'(N_STU) - n_below;
endmodule

// File: rtl/cc_rank_sched.sv
// Serial front-end and scheduler: capture seven scores, evaluate once, stream ranked IDs.
module cc_rank_sched
  import cc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  cc_rank_sched_if.slave  bus
);
  state_e                        state_q, state_d;
  logic [ID_W-1:0]               idx_q, idx_d;
  logic [N_STU-1:0][SCORE_W-1:0] score_q;
  cfg_t                          cfg_q;
  logic [N_STU-1:0][ID_W-1:0]    ids_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [N_STU-1:0][EXT_W-1:0]   ext;
  logic [N_STU-1:0][ID_W-1:0]    core_id;
  logic [CNT_W-1:0]              core_cnt;
  logic                          take;

  assign take = bus.in_valid && (state_q == ST_IDLE || state_q == ST_LOAD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        state_d = ST_LOAD;
        idx_d   = ID_W'(1);
      end
      ST_LOAD: if (bus.in_valid) begin
        if (idx_q == ID_W'(N_STU-1)) begin
          state_d = ST_CALC;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end
      ST_CALC: begin
        state_d = ST_OUT;
        idx_d   = '0;
      end
      default: begin
        if (idx_q == ID_W'(N_STU-1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      score_q <= '0;
      cfg_q   <= '0;
      ids_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (take) score_q[idx_q] <= bus.in_score;
      if (bus.in_valid && state_q == ST_IDLE)
        cfg_q <= '{sgn: bus.in_opt[0], desc: bus.in_opt[1], fail: bus.in_opt[2],
                   a: bus.in_a, b: bus.in_b};
      if (state_q == ST_CALC) begin
        ids_q <= core_id;
        cnt_q <= core_cnt;
      end
    end
  end

  for (genvar g = 0; g < N_STU; g++) begin : g_ext
    assign ext[g] = ext_score(score_q[g], cfg_q.sgn);
  end

  cc_rank_core u_core (
    .ext_i (ext),
    .cfg_i (cfg_q),
    .id_o  (core_id),
    .cnt_o (core_cnt)
  );

  // Outputs decode registered state only, so they are zero outside OUT and during reset.
  assign bus.busy      = state_q != ST_IDLE;
  assign bus.out_valid = state_q == ST_OUT;
  assign bus.out_id    = (state_q == ST_OUT) ? ids_q[idx_q] : '0;
  assign bus.out_cnt   = (state_q == ST_OUT) ? cnt_q : '0;
endmodule

// File: tb/tb_cc_rank_sched.sv
// Scoreboard bench for cc_rank_sched: directed scenarios plus randomized jobs vs. a behavioural model.
module tb_cc_rank_sched;
  import cc_pkg::*;

  typedef struct { int id; int cnt; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cc_rank_sched_if bus();

  cc_rank_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;
  int beat_in_job = 0;
  int starts = 0;
  int ends = 0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: stable insertion sort on signed ints, truncating integer division.
  task automatic model(input int opt, input int a, input int b, input int sc[7]);
    int v[7];
    int ord[7];
    int sum, avg, thr, t, cnt, tmp;
    bit desc;
    desc = ((opt >> 1) & 1) != 0;
    sum = 0;
    for (int i = 0; i < 7; i++) begin
      v[i] = ((opt & 1) != 0 && sc[i] >= 8) ? sc[i] - 16 : sc[i];
      sum += v[i];
      ord[i] = i;
    end
    for (int i = 1; i < 7; i++)
      for (int j = i; j > 0; j--) begin
        if (desc ? (v[ord[j]] > v[ord[j-1]]) : (v[ord[j]] < v[ord[j-1]])) begin
          tmp = ord[j]; ord[j] = ord[j-1]; ord[j-1] = tmp;
        end else break;
      end
    avg = sum / 7;
    thr = avg - a - b;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (a == 0) t = v[i];
      else if (v[i] >= 0) t = v[i] * (a + 1);
      else t = v[i] / (a + 1);
      if (t < thr) cnt++;
    end
    if ((opt & 4) == 0) cnt = 7 - cnt;
    for (int i = 0; i < 7; i++) sb.push_back('{ord[i], cnt});
  endtask

  // Monitor: pops one expectation per valid beat; also tracks busy and idle-zero outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      beat_in_job = 0;
      sb.delete();
    end else begin
      chk("busy", int'(bus.busy), (starts != ends) ? 1 : 0);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat_id", int'(bus.out_id), -1);
        end else begin
          e = sb.pop_front();
          chk("out_id", int'(bus.out_id), e.id);
          chk("out_cnt", int'(bus.out_cnt), e.cnt);
          if (beat_in_job == 0) chk("first_valid_edges_after_last_beat", cyc + 1 - last_edge, 2);
          beat_in_job++;
          if (beat_in_job == 7) begin
            beat_in_job = 0;
            ends++;
          end
        end
      end else begin
        chk("idle_out_id", int'(bus.out_id), 0);
        chk("idle_out_cnt", int'(bus.out_cnt), 0);
      end
    end
  end

  task automatic drive_job(input int opt, input int a, input int b, input int sc[7],
                           input int mingap, input int maxgap, input bit hold);
    int gap;
    model(opt, a, b, sc);
    for (int k = 0; k < 7; k++) begin
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, mingap)) : 0;
      repeat (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_score = 4'($urandom);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_score = 4'(sc[k]);
      bus.in_opt   = (k == 0) ? 3'(opt) : 3'($urandom);
      bus.in_a     = (k == 0) ? 2'(a)   : 2'($urandom);
      bus.in_b     = (k == 0) ? 3'(b)   : 3'($urandom);
      @(posedge clk);
      #1;
      if (k == 0) starts++;
      if (k == 6) last_edge = cyc;
    end
    @(negedge clk);
    bus.in_valid = hold;
    if (hold) begin
      // Held through CALC and every OUT beat, dropped just before the FSM returns to IDLE.
      repeat (8) begin
        bus.in_score = 4'($urandom);
        bus.in_opt   = 3'($urandom);
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 60) chk("drain_timeout", n, 0);
    @(negedge clk);
  endtask

  initial begin
    int s1[7];
    int s2[7];
    int s3[7];
    int s4[7];
    int sr[7];
    int n;
    s1 = '{6, 5, 4, 3, 2, 1, 0};
    s2 = '{5, 5, 5, 5, 5, 5, 5};
    s3 = '{7, 7, 7, 8, 8, 8, 0};
    s4 = '{15, 15, 15, 15, 15, 15, 15};
    bus.in_valid = 1'b0;
    bus.in_score = '0;
    bus.in_opt   = '0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_id", int'(bus.out_id), 0);
    chk("reset_out_cnt", int'(bus.out_cnt), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    drive_job(0, 0, 0, s1, 0, 0, 1'b0); drain();
    drive_job(6, 1, 1, s2, 0, 0, 1'b0); drain();
    drive_job(5, 1, 0, s3, 0, 0, 1'b0); drain();
    drive_job(1, 3, 0, s4, 0, 0, 1'b0); drain();
    drive_job(0, 0, 0, s1, 1, 3, 1'b1); drain();
    repeat (3) @(negedge clk);

    // Reset while the third result beat is on the bus.
    drive_job(0, 0, 0, s1, 0, 0, 1'b0);
    n = 0;
    while (beat_in_job < 3 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) chk("wait_third_beat_timeout", n, 0);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", int'(bus.out_valid), 0);
    chk("midreset_out_id", int'(bus.out_id), 0);
    chk("midreset_out_cnt", int'(bus.out_cnt), 0);
    chk("midreset_busy", int'(bus.busy), 0);
    starts = ends;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    drive_job(5, 1, 0, s3, 0, 0, 1'b0); drain();

    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < 7; i++) sr[i] = int'($urandom_range(15, 0));
      drive_job(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)), int'($urandom_range(7, 0)),
                sr, 0, int'($urandom_range(2, 0)), 1'($urandom));
      drain();
    end

    chk("final_queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cc_rank_sched.md
# cc_rank_sched

Sequential front-end and scheduler for the seven-student score-ranking datapath. It collects seven 4-bit scores serially with one configuration word, launches one rank-and-grade computation, then streams the seven ranked student IDs and a pass/fail count serially. It sits between the serial test interface and the combinational ranking core, and serialises all traffic into that core.

## Interface
- No parameters; student count is fixed at 7.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  score beat valid; beats may be non-contiguous
- in_score  in  4  score of student k, where k counts accepted beats 0..6
- in_opt  in  3  [0] signed scores, [1] descending sort, [2] report fail count (else pass count); sampled on beat 0 only
- in_a  in  2  linear-transform selector; sampled on beat 0 only
- in_b  in  3  threshold offset; sampled on beat 0 only
- busy  out  1  high from beat 0 until the last output beat; in_valid ignored while in CALC/OUT
- out_valid  out  1  result beat valid
- out_id  out  3  ranked student ID, rank 0 first
- out_cnt  out  3  pass or fail count, constant across all 7 result beats

## Operation
- FSM states: IDLE, LOAD, CALC, OUT.
- IDLE: in_valid=1 stores score 0 and latches opt/a/b, idx<=1 -> LOAD.
- LOAD: each in_valid=1 stores score[idx], idx++. On beat 6 -> CALC. in_valid=0 holds state; there is no timeout.
- CALC: one cycle. The core evaluates; out_id[0..6] and out_cnt are registered -> OUT, idx<=0.
- OUT: out_valid=1 for 7 consecutive cycles, out_id=rank[idx]. After idx 6 -> IDLE. in_valid is ignored throughout CALC and OUT.
- Score extension: zero-extend to 5-bit when opt[0]=0; sign-extend when opt[0]=1.
- Sort: ascending, or descending when opt[1]=1. Equal scores keep the lower ID first (stable).
- Average: 8-bit signed sum of all seven scores / 7, truncated toward zero, held as 5-bit signed.
- Threshold: 7-bit signed, equal to avg - a - b.
- Transform per score x (7-bit signed result):
  - a=0: x.
  - x>=0: a=1 gives 2x, a=2 gives 3x, a=3 gives 4x.
  - x<0: a=1 gives x/2, a=2 gives x/3, a=3 gives x/4, all truncated toward zero.
- Count: number of transformed scores < threshold (signed compare). out_cnt = count when opt[2]=1, else 7-count.
- Reset at any time: state IDLE, idx=0, all stored scores and config cleared. Any in-flight job is discarded with no partial output.

## Timing
- Reset values: busy=0, out_valid=0, out_id=0, out_cnt=0.
- Outputs are registered; no combinational path from inputs to outputs.
- Last input beat at edge T: CALC during cycle T+1, first out_valid at T+2, last at T+8.
- Earliest next beat 0 is accepted at T+9, when the FSM is back in IDLE. An in_valid coinciding with the final OUT cycle is dropped.
- busy rises on the edge that accepts beat 0 and falls on the edge leaving OUT.
- out_id and out_cnt are 0 whenever out_valid=0.

## Structure
- Shared package cc_pkg holds:
  - N_STU=7.
  - State enum {IDLE, LOAD, CALC, OUT}.
  - Widths SCORE_W=4, EXT_W=5, LIN_W=7, ID_W=3.
  - Transform-select encodings.
- Sub-module cc_rank_core is purely combinational: 7 extended scores plus config in, 7 IDs plus count out. It holds the sorting network, average, transform and compare.
- The FSM, index counter and capture/output registers live in cc_rank_sched.

## Test plan
- Unsigned ascending pass count:
  - Stimulus: opt=000, a=0, b=0, scores 6,5,4,3,2,1,0.
  - Response: IDs 6,5,4,3,2,1,0; out_cnt=4. First out_valid 2 cycles after the last beat.
- All-equal descending fail count with ties:
  - Stimulus: opt=110, a=1, b=1, all scores 5.
  - Response: IDs 0..6 in order; out_cnt=0.
- Signed with negative transform:
  - Stimulus: opt=101, a=1, b=0, scores 7,7,7,-8,-8,-8,0.
  - Response: avg=0, threshold=-1; IDs 3,4,5,6,0,1,2; out_cnt=3.
- Signed, all scores -1:
  - Stimulus: opt=001, a=3, b=0.
  - Response: threshold=-4, transformed=0; out_cnt=7.
- Pauses and ignored input:
  - Stimulus: repeat the first scenario with in_valid=0 gaps of 1-3 cycles between beats; hold in_valid=1 during CALC/OUT.
  - Response: identical results; busy stays high throughout the job; extra beats are not captured.
- Reset mid-OUT:
  - Stimulus: assert rst_n=0 at the third result beat.
  - Response: all outputs go to 0 immediately. A fresh job run after reset produces correct results.
